uart_tx_arbiter: RTL and testbench
==================================

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter START_TO, default 16, max clk cycles from tx_enable pulse to tx_busy rising before abort.
REQ-002 clk  input  1  single clock; all state on rising edge.
REQ-003 n_rst  input  1  reset, asynchronous, active-low.
REQ-004 req0  input  1  requester 0 send request; level, held until ack0.
REQ-005 data0  input  8  requester 0 byte; valid while req0=1.
REQ-006 ack0  output  1  one-cycle pulse: requester 0 byte finished or aborted.
REQ-007 req1, data1, ack1  in/in/out  1/8/1  requester 1, same rules as requester 0.
REQ-008 tx_enable  output  1  one-cycle start pulse to transmitter enable.
REQ-009 tx_data  output  8  byte presented to transmitter data inputs.
REQ-010 tx_busy  input  1  transmitter UART_BUSY.
REQ-011 grant  output  2  one-hot owner; 00 when idle.
REQ-012 err_to  output  1  sticky start-timeout flag.
REQ-013 err_clr  input  1  synchronous clear of err_to.

Function
REQ-014 FSM states: IDLE, LOAD, WAIT_BUSY, WAIT_DONE, ACK; exactly one state active.
REQ-015 IDLE: arbitrate only when tx_busy=0 and (req0|req1)=1; otherwise stay.
REQ-016 Arbitration round-robin: one requester -> that requester; both -> the one not served last; last-served pointer resets to 1 (requester 0 wins first tie).
REQ-017 On grant: capture selected dataN into tx_data register, set grant one-hot, go LOAD.
REQ-018 LOAD: tx_enable=1 for exactly this one cycle; go WAIT_BUSY; timeout counter cleared.
REQ-019 WAIT_BUSY: tx_busy=1 -> WAIT_DONE; counter reaches START_TO with tx_busy=0 -> set err_to, go ACK (abort).
REQ-020 WAIT_DONE: stay while tx_busy=1; tx_busy=0 -> ACK; no timeout in this state.
REQ-021 ACK: ackN=1 for the granted requester only, one cycle; update last-served pointer; grant cleared on exit; go IDLE.
REQ-022 Min request-to-request spacing: IDLE->LOAD->WAIT_BUSY->...->ACK->IDLE; new grant no earlier than cycle after return to IDLE.
REQ-023 tx_data stable from LOAD through ACK; changes to dataN after grant ignored.
REQ-024 reqN deasserted mid-transfer: transfer completes, ackN still pulses.
REQ-025 reqN held after ackN is treated as a new request (next byte).
REQ-026 ack0 and ack1 never high in the same cycle; tx_enable never high outside LOAD.
REQ-027 err_clr and timeout in same cycle: err_to set (set wins).
REQ-028 Timeout counter width ceil(log2(START_TO+1)), saturating, no wrap.

Reset
REQ-029 n_rst=0 asynchronously forces: state IDLE, grant=00, ack0=ack1=0, tx_enable=0, tx_data=00h, err_to=0, counter=0, pointer=1.
REQ-030 Reset mid-transfer abandons the byte without ack; after release, arbitration restarts per REQ-015.
REQ-031 First grant possible on first clk edge after n_rst deasserts.

Verification
REQ-032 req0=1,data0=41h; transmitter model raises tx_busy 2 cycles after tx_enable, drops after 100 -> one tx_enable, tx_data=41h, grant=01, single ack0, err_to=0.
REQ-033 req0,req1 both held high, data0=AAh,data1=55h -> served order 0,1,0,1; tx_data AAh,55h,AAh,55h; acks alternate.
REQ-034 tx_busy held 1 at time of req1 -> no grant/tx_enable until tx_busy=0, then grant=10.
REQ-035 tx_busy never rises, START_TO=16 -> ack0 pulse 16 cycles after WAIT_BUSY entry, err_to=1 until err_clr pulse, then 0.
REQ-036 n_rst low during WAIT_DONE -> all outputs at reset values immediately, no ack; after release pending req1 granted first if req0=0.
REQ-037 data0 changed from 12h to 34h during WAIT_DONE -> tx_data stays 12h until ACK.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin arbiter that lets two byte requesters share
// one UART transmitter. A granted byte is latched, started with a one-cycle
// tx_enable pulse, and acknowledged once the transmitter finishes. If the
// transmitter never reports busy within START_TO cycles, the byte is
// acknowledged anyway and the sticky err_to flag is raised.
module uart_tx_arbiter #(
  parameter int START_TO = 16
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       req0,
  input  logic [7:0] data0,
  output logic       ack0,
  input  logic       req1,
  input  logic [7:0] data1,
  output logic       ack1,
  output logic       tx_enable,
  output logic [7:0] tx_data,
  input  logic       tx_busy,
  output logic [1:0] grant,
  output logic       err_to,
  input  logic       err_clr
);

  // Wide enough to hold START_TO itself; the counter saturates there.
  localparam int CW = (START_TO < 1) ? 1 : $clog2(START_TO + 1);
  localparam logic [CW-1:0] TO_MAX = CW'(START_TO);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_LOAD      = 3'd1;
  localparam logic [2:0] S_WAIT_BUSY = 3'd2;
  localparam logic [2:0] S_WAIT_DONE = 3'd3;
  localparam logic [2:0] S_ACK       = 3'd4;

  logic [2:0]    state_q, state_d;
  logic [1:0]    grant_q, grant_d;
  logic [7:0]    data_q,  data_d;
  logic [CW-1:0] cnt_q,   cnt_d;
  logic          last_q,  last_d;   // 1: requester 1 was served last
  logic          err_q,   err_d;

  logic          pick1;
  logic          timeout;
  logic [CW-1:0] cnt_inc;

  // Next-state, arbitration, start-timeout and error-flag logic.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    timeout = 1'b0;
    // On a tie the requester that was not served last wins.
    pick1   = req1 & (~req0 | ~last_q);
    cnt_inc = (cnt_q == TO_MAX) ? cnt_q : cnt_q + CW'(1);

    case (state_q)
      S_IDLE: begin
        if (!tx_busy && (req0 || req1)) begin
          grant_d = pick1 ? 2'b10 : 2'b01;
          data_d  = pick1 ? data1 : data0;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        cnt_d   = '0;
        state_d = S_WAIT_BUSY;
      end
      S_WAIT_BUSY: begin
        if (tx_busy) begin
          state_d = S_WAIT_DONE;
        end else begin
          cnt_d = cnt_inc;
          if (cnt_inc == TO_MAX) begin
            timeout = 1'b1;
            state_d = S_ACK;
          end
        end
      end
      S_WAIT_DONE: begin
        if (!tx_busy) begin
          state_d = S_ACK;
        end
      end
      S_ACK: begin
        last_d  = grant_q[1];
        grant_d = 2'b00;
        state_d = S_IDLE;
      end
      default: begin
        grant_d = 2'b00;
        state_d = S_IDLE;
      end
    endcase

    // A timeout in the same cycle as a clear request keeps the flag set.
    if (timeout) begin
      err_d = 1'b1;
    end else if (err_clr) begin
      err_d = 1'b0;
    end else begin
      err_d = err_q;
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= S_IDLE;
      grant_q <= 2'b00;
      data_q  <= 8'h00;
      cnt_q   <= '0;
      last_q  <= 1'b1;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      err_q   <= err_d;
    end
  end

  // Pulses are pure state decodes, so reset clears them immediately.
  assign tx_enable = (state_q == S_LOAD);
  assign ack0      = (state_q == S_ACK) & grant_q[0];
  assign ack1      = (state_q == S_ACK) & grant_q[1];
  assign tx_data   = data_q;
  assign grant     = grant_q;
  assign err_to    = err_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: transaction-level reference model compared
// every cycle, a simple transmitter model, and directed scenarios with
// literal expectations.
module tb_uart_tx_arbiter;
  localparam int START_TO = 16;

  logic       clk = 1'b0;
  logic       n_rst = 1'b0;
  logic       req0 = 1'b0, req1 = 1'b0;
  logic [7:0] data0 = 8'h00, data1 = 8'h00;
  logic       ack0, ack1, tx_enable, err_to;
  logic [7:0] tx_data;
  logic [1:0] grant;
  logic       tx_busy;
  logic       err_clr = 1'b0;

  logic auto_busy = 1'b0, force_busy = 1'b0, xmit_on = 1'b1;
  int   busy_len = 100;
  assign tx_busy = auto_busy | force_busy;

  int n_vec = 0, n_err = 0, cyc = 0;

  uart_tx_arbiter #(.START_TO(START_TO)) dut (
    .clk(clk), .n_rst(n_rst),
    .req0(req0), .data0(data0), .ack0(ack0),
    .req1(req1), .data1(data1), .ack1(ack1),
    .tx_enable(tx_enable), .tx_data(tx_data), .tx_busy(tx_busy),
    .grant(grant), .err_to(err_to), .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  // Transmitter model: busy rises 2 cycles after the start pulse.
  always @(negedge clk) begin
    if (xmit_on && tx_enable) begin
      repeat (2) @(negedge clk);
      auto_busy = 1'b1;
      repeat (busy_len) @(negedge clk);
      auto_busy = 1'b0;
    end
  end

  // Reference model: owner of the current byte, cycles since grant,
  // whether the transmitter has been seen busy, and the ack cycle.
  int         m_owner, m_age, m_last;
  logic       m_busy_seen, m_ack, m_err, m_to;
  logic [7:0] m_data;

  always @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      m_owner = -1; m_age = 0; m_last = 1;
      m_busy_seen = 0; m_ack = 0; m_err = 0; m_data = 8'h00;
    end else begin
      m_to = 0;
      if (m_owner < 0) begin
        if (!tx_busy && (req0 || req1)) begin
          if (req0 && req1) m_owner = 1 - m_last;
          else m_owner = req0 ? 0 : 1;
          m_data = (m_owner == 0) ? data0 : data1;
          m_age = 0; m_busy_seen = 0; m_ack = 0;
        end
      end else if (m_ack) begin
        m_last = m_owner;
        m_owner = -1;
        m_ack = 0;
      end else begin
        if (m_age >= 1) begin
          if (m_busy_seen) begin
            if (!tx_busy) m_ack = 1;
          end else if (tx_busy) begin
            m_busy_seen = 1;
          end else if (m_age == START_TO) begin
            m_to = 1; m_ack = 1;
          end
        end
        m_age++;
      end
      if (m_to) m_err = 1;
      else if (err_clr) m_err = 0;
    end
  end

  // Monitor bookkeeping read by the scenarios.
  int         en_cnt, ack0_cnt, ack1_cnt, en_cyc, ack_cyc;
  logic [1:0] first_grant;
  int         ack_q[$];
  logic [7:0] en_data[$];

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // Per-cycle compare against the model plus transaction monitor.
  always @(negedge clk) begin
    logic [1:0] e_grant;
    logic       e_en;
    cyc++;
    n_vec++;
    e_grant = (m_owner == 0) ? 2'b01 : (m_owner == 1) ? 2'b10 : 2'b00;
    e_en    = (m_owner >= 0) && (m_age == 0) && !m_ack;
    cmp("grant", {30'd0, grant}, {30'd0, e_grant});
    cmp("tx_enable", {31'd0, tx_enable}, {31'd0, e_en});
    cmp("ack0", {31'd0, ack0}, {31'd0, m_ack && m_owner == 0});
    cmp("ack1", {31'd0, ack1}, {31'd0, m_ack && m_owner == 1});
    cmp("tx_data", {24'd0, tx_data}, {24'd0, m_data});
    cmp("err_to", {31'd0, err_to}, {31'd0, m_err});
    if (tx_enable) begin en_cnt++; en_cyc = cyc; en_data.push_back(tx_data); end
    if (ack0) begin ack0_cnt++; ack_cyc = cyc; ack_q.push_back(0); end
    if (ack1) begin ack1_cnt++; ack_cyc = cyc; ack_q.push_back(1); end
    if (first_grant == 2'b00 && grant != 2'b00) first_grant = grant;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    cmp(name, act, exp);
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin @(negedge clk); #1; end
  endtask

  task automatic clr_mon();
    en_cnt = 0; ack0_cnt = 0; ack1_cnt = 0;
    ack_q.delete(); en_data.delete(); first_grant = 2'b00;
  endtask

  // who: 0, 1, or -1 for either requester.
  task automatic wait_ack(input int who, input int maxc);
    bit hit = 0;
    for (int i = 0; i < maxc && !hit; i++) begin
      tick();
      if ((who != 1 && ack0) || (who != 0 && ack1)) hit = 1;
    end
    n_vec++;
    if (!hit) begin
      n_err++;
      $display("FAIL wait_ack%0d: no ack within %0d cycles", who, maxc);
    end
  endtask

  task automatic wait_busy(input int maxc);
    bit hit = 0;
    for (int i = 0; i < maxc && !hit; i++) begin
      tick();
      if (tx_busy) hit = 1;
    end
    n_vec++;
    if (!hit) begin
      n_err++;
      $display("FAIL wait_busy: tx_busy not seen within %0d cycles", maxc);
    end
  endtask

  task automatic do_reset();
    tick();
    n_rst = 1'b0;
    tick(2);
    n_rst = 1'b1;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    clr_mon();
    tick(2);
    // Reset state
    check("rst_grant", {30'd0, grant}, 32'h0);
    check("rst_tx_data", {24'd0, tx_data}, 32'h0);
    check("rst_tx_enable", {31'd0, tx_enable}, 32'h0);
    check("rst_err_to", {31'd0, err_to}, 32'h0);
    n_rst = 1'b1;

    // Single byte from requester 0
    busy_len = 100;
    req0 = 1; data0 = 8'h41;
    wait_ack(0, 200);
    check("t1_grant", {30'd0, grant}, 32'h1);
    check("t1_tx_data", {24'd0, tx_data}, 32'h41);
    check("t1_err_to", {31'd0, err_to}, 32'h0);
    req0 = 0;
    tick(3);
    check("t1_en_cnt", en_cnt, 1);
    check("t1_ack0_cnt", ack0_cnt, 1);
    check("t1_ack1_cnt", ack1_cnt, 0);

    // Both held: alternating service starting with requester 0
    do_reset();
    clr_mon();
    busy_len = 5;
    req0 = 1; data0 = 8'hAA; req1 = 1; data1 = 8'h55;
    for (int k = 0; k < 4; k++) wait_ack(-1, 100);
    req0 = 0; req1 = 0;
    tick(3);
    check("t2_acks", ack_q.size(), 4);
    if (ack_q.size() == 4) begin
      check("t2_order0", ack_q[0], 0);
      check("t2_order1", ack_q[1], 1);
      check("t2_order2", ack_q[2], 0);
      check("t2_order3", ack_q[3], 1);
    end
    if (en_data.size() == 4) begin
      check("t2_data0", {24'd0, en_data[0]}, 32'hAA);
      check("t2_data1", {24'd0, en_data[1]}, 32'h55);
      check("t2_data2", {24'd0, en_data[2]}, 32'hAA);
      check("t2_data3", {24'd0, en_data[3]}, 32'h55);
    end else begin
      check("t2_en_cnt", en_data.size(), 4);
    end

    // Transmitter busy blocks arbitration
    clr_mon();
    force_busy = 1;
    req1 = 1; data1 = 8'h77;
    tick(10);
    check("t3_no_grant", {30'd0, grant}, 32'h0);
    check("t3_no_en", en_cnt, 0);
    force_busy = 0;
    wait_ack(1, 200);
    req1 = 0;
    check("t3_first_grant", {30'd0, first_grant}, 32'h2);
    tick(2);

    // Start timeout: ack 16 cycles after entering the wait-for-busy phase
    clr_mon();
    xmit_on = 0;
    req0 = 1; data0 = 8'h99;
    wait_ack(0, 100);
    check("t4_to_latency", ack_cyc - en_cyc, 17);
    check("t4_err_set", {31'd0, err_to}, 32'h1);
    req0 = 0;
    tick(3);
    check("t4_err_sticky", {31'd0, err_to}, 32'h1);
    err_clr = 1;
    tick();
    err_clr = 0;
    tick();
    check("t4_err_cleared", {31'd0, err_to}, 32'h0);
    // Clear held through a timeout: the set still wins
    err_clr = 1;
    req0 = 1;
    wait_ack(0, 100);
    check("t4_set_wins", {31'd0, err_to}, 32'h1);
    req0 = 0;
    tick();
    check("t4_clr_after", {31'd0, err_to}, 32'h0);
    err_clr = 0;
    xmit_on = 1;
    tick(2);

    // Captured byte ignores later data changes
    clr_mon();
    busy_len = 30;
    req0 = 1; data0 = 8'h12;
    wait_busy(50);
    tick(3);
    data0 = 8'h34;
    tick(5);
    check("t5_data_hold", {24'd0, tx_data}, 32'h12);
    wait_ack(0, 100);
    check("t5_data_at_ack", {24'd0, tx_data}, 32'h12);
    req0 = 0;
    tick(3);

    // Reset during transfer: no ack, pending requester 1 served after
    busy_len = 100;
    req0 = 1; data0 = 8'h21;
    wait_busy(50);
    tick(3);
    req0 = 0; req1 = 1; data1 = 8'h65;
    clr_mon();
    #2 n_rst = 0;
    #1;
    check("t6_rst_grant", {30'd0, grant}, 32'h0);
    check("t6_rst_en", {31'd0, tx_enable}, 32'h0);
    check("t6_rst_ack", {30'd0, ack1, ack0}, 32'h0);
    check("t6_rst_data", {24'd0, tx_data}, 32'h0);
    tick(2);
    n_rst = 1;
    wait_ack(1, 400);
    req1 = 0;
    check("t6_no_ack0", ack0_cnt, 0);
    check("t6_first_grant", {30'd0, first_grant}, 32'h2);
    check("t6_data", {24'd0, tx_data}, 32'h65);
    tick(5);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
